hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core. It drives the select lines of the E-stage operand Mux3x1 instances (forward_a_e, forward_b_e) and the stall and flush enables of the F/D/E/M/W pipeline registers. It resolves load-use hazards, taken-branch redirects and multi-cycle data-memory waits. It also keeps saturating stall and flush performance counters and a memory-timeout error flag.

---
 rtl/hazard_ctrl.sv | 81 ++++++++
 tb/tb_hazard_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/branch/memory-wait hazard resolution, E-stage forwarding selects, perf counters and memory timeout flag
module hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             load_e,
  input  logic             pc_src_e,
  input  logic             mem_access_m,
  input  logic             dmem_ready,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             stall_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic mem_stall, lu_stall, br_flush, err_n;
  logic [1:0] fwd_a_n, fwd_b_n;
  always_comb begin
    mem_stall = mem_access_m & ~dmem_ready;
    lu_stall = ~mem_stall & ~pc_src_e & load_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
    br_flush = ~mem_stall & pc_src_e;
    stall_f = ~rst & (mem_stall | lu_stall);
    stall_d = stall_f;
    stall_e = ~rst & mem_stall;
    stall_m = stall_e;
    stall_w = stall_e;
    flush_d = rst | br_flush;
    flush_e = rst | br_flush | lu_stall;
    fwd_a_n = (reg_write_e & (rd_e != 5'd0) & (rd_e == rs1_d)) ? 2'b10 :
              (reg_write_m & (rd_m != 5'd0) & (rd_m == rs1_d)) ? 2'b01 : 2'b00;
    fwd_b_n = (reg_write_e & (rd_e != 5'd0) & (rd_e == rs2_d)) ? 2'b10 :
              (reg_write_m & (rd_m != 5'd0) & (rd_m == rs2_d)) ? 2'b01 : 2'b00;
  end
  // wait_cnt counts cycles spent in MEM_WAIT still waiting; entry cycle from RUN is not counted
  always_comb begin
    state_n = (state == RUN) ? (mem_stall ? MEM_WAIT : RUN) : (dmem_ready ? RUN : MEM_WAIT);
    wait_n = (state == RUN) ? '0 :
             (~dmem_ready & (wait_cnt != WW'(MEM_TIMEOUT))) ? wait_cnt + 1'b1 : wait_cnt;
    err_n = mem_err | ((state == MEM_WAIT) & (wait_n == WW'(MEM_TIMEOUT)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wait_cnt <= '0;
      mem_err <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      forward_a_e <= 2'b00;
      forward_b_e <= 2'b00;
    end else begin
      state <= state_n;
      wait_cnt <= wait_n;
      mem_err <= err_n;
      stall_cnt <= stall_cnt + CNT_W'(stall_f & ~&stall_cnt);
      flush_cnt <= flush_cnt + CNT_W'(br_flush & ~&flush_cnt);
      if (!stall_e) begin
        forward_a_e <= flush_e ? 2'b00 : fwd_a_n;
        forward_b_e <= flush_e ? 2'b00 : fwd_b_n;
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven vectors plus directed multi-cycle sequences for hazard_ctrl
module tb_hazard_ctrl;
  logic clk = 0, rst;
  logic [4:0] rs1, rs2, rde, rdm;
  logic rwe, rwm, ld, pc, ma, rdy;
  logic [1:0] fa, fb;
  logic sf, sd, se, sm, sw, fd, fe, merr;
  logic [3:0] scnt, fcnt;
  int n_cmp, n_bad;

  hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .rs1_d(rs1), .rs2_d(rs2), .rd_e(rde), .rd_m(rdm),
    .reg_write_e(rwe), .reg_write_m(rwm), .load_e(ld), .pc_src_e(pc),
    .mem_access_m(ma), .dmem_ready(rdy), .forward_a_e(fa), .forward_b_e(fb),
    .stall_f(sf), .stall_d(sd), .stall_e(se), .stall_m(sm), .stall_w(sw),
    .flush_d(fd), .flush_e(fe), .stall_cnt(scnt), .flush_cnt(fcnt), .mem_err(merr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rde, rdm;
    logic rwe, rwm, ld, pc, ma, rdy;
    logic sf, se, fd, fe;
    logic [1:0] fa, fb;
  } vec_t;
  vec_t v[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rde = 0; rdm = 0;
    rwe = 0; rwm = 0; ld = 0; pc = 0; ma = 0; rdy = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst = 1; ma = 1; rdy = 0; pc = 1; ld = 1; rwe = 1; rde = 7; rs1 = 7;
    @(negedge clk);
    chk("rst_stall_f", sf, 0);
    chk("rst_stall_e", se, 0);
    chk("rst_flush_d", fd, 1);
    chk("rst_flush_e", fe, 1);
    tick();
    chk("rst_fwd_a", fa, 0);
    chk("rst_fwd_b", fb, 0);
    chk("rst_stall_cnt", scnt, 0);
    chk("rst_flush_cnt", fcnt, 0);
    chk("rst_mem_err", merr, 0);
    rst = 0;
    idle();

    //       rs1 rs2 rde rdm rwe rwm ld pc ma rdy  sf se fd fe  fa     fb
    v[0]  = '{5, 3, 5, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2'b10, 2'b00};
    v[1]  = '{5, 3, 0, 5, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 2'b01, 2'b00};
    v[2]  = '{6, 6, 6, 6, 1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 2'b10, 2'b10};
    v[3]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 2'b00, 2'b00};
    v[4]  = '{1, 7, 7, 0, 1, 0, 1, 0, 0, 1,  1, 0, 0, 1, 2'b00, 2'b00};
    v[5]  = '{1, 7, 0, 7, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 2'b00, 2'b01};
    v[6]  = '{7, 2, 7, 0, 1, 0, 1, 1, 0, 1,  0, 0, 1, 1, 2'b00, 2'b00};
    v[7]  = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 1,  0, 0, 0, 0, 2'b00, 2'b00};
    v[8]  = '{9, 9, 9, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2'b10, 2'b10};
    v[9]  = '{3, 4, 3, 0, 1, 0, 0, 1, 1, 0,  1, 1, 0, 0, 2'b10, 2'b10};
    v[10] = '{3, 4, 3, 0, 1, 0, 0, 1, 1, 1,  0, 0, 1, 1, 2'b00, 2'b00};
    v[11] = '{8, 0, 8, 0, 1, 0, 1, 0, 1, 0,  1, 1, 0, 0, 2'b00, 2'b00};
    v[12] = '{8, 0, 8, 0, 1, 0, 1, 0, 0, 1,  1, 0, 0, 1, 2'b00, 2'b00};
    for (int i = 0; i < 13; i++) begin
      rs1 = v[i].rs1; rs2 = v[i].rs2; rde = v[i].rde; rdm = v[i].rdm;
      rwe = v[i].rwe; rwm = v[i].rwm; ld = v[i].ld; pc = v[i].pc;
      ma = v[i].ma; rdy = v[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_stall_f", i), sf, v[i].sf);
      chk($sformatf("v%0d_stall_d", i), sd, v[i].sf);
      chk($sformatf("v%0d_stall_e", i), se, v[i].se);
      chk($sformatf("v%0d_stall_m", i), sm, v[i].se);
      chk($sformatf("v%0d_stall_w", i), sw, v[i].se);
      chk($sformatf("v%0d_flush_d", i), fd, v[i].fd);
      chk($sformatf("v%0d_flush_e", i), fe, v[i].fe);
      tick();
      chk($sformatf("v%0d_fwd_a", i), fa, v[i].fa);
      chk($sformatf("v%0d_fwd_b", i), fb, v[i].fb);
    end

    do_reset();
    ld = 1; rwe = 1; rde = 7; rs2 = 7;
    tick();
    idle();
    tick();
    chk("lu_stall_cnt", scnt, 1);
    chk("lu_flush_cnt", fcnt, 0);
    pc = 1; ld = 1; rwe = 1; rde = 7; rs1 = 7;
    @(negedge clk);
    chk("brlu_stall_f", sf, 0);
    chk("brlu_flush_d", fd, 1);
    chk("brlu_flush_e", fe, 1);
    tick();
    idle();
    chk("brlu_flush_cnt", fcnt, 1);
    chk("brlu_stall_cnt", scnt, 1);

    do_reset();
    ma = 1; rdy = 0; pc = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mw%0d_stall_f", k), sf, 1);
      chk($sformatf("mw%0d_stall_w", k), sw, 1);
      chk($sformatf("mw%0d_flush_d", k), fd, 0);
      chk($sformatf("mw%0d_flush_e", k), fe, 0);
      tick();
    end
    rdy = 1;
    @(negedge clk);
    chk("mw_rdy_flush_d", fd, 1);
    chk("mw_rdy_flush_e", fe, 1);
    chk("mw_rdy_stall_e", se, 0);
    tick();
    idle();
    chk("mw_stall_cnt", scnt, 3);
    chk("mw_flush_cnt", fcnt, 1);

    do_reset();
    ma = 1; rdy = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("to%0d_mem_err", k), merr, k >= 5);
    end
    rst = 1;
    @(negedge clk);
    chk("to_rst_stall_f", sf, 0);
    chk("to_rst_flush_e", fe, 1);
    tick();
    chk("to_rst_mem_err", merr, 0);
    chk("to_rst_stall_cnt", scnt, 0);
    rst = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("re%0d_mem_err", k), merr, k >= 5);
    end

    do_reset();
    ma = 1; rdy = 0;
    repeat (20) tick();
    chk("sat_stall_cnt", scnt, 4'hf);
    rdy = 1; pc = 1;
    repeat (20) tick();
    chk("sat_flush_cnt", fcnt, 4'hf);
    chk("sat_stall_hold", scnt, 4'hf);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
